busca_instrucao: RTL and testbench
==================================

// Module: busca_instrucao
// PURPOSE
//  Instruction-fetch responder serving the multicycle control unit. Owns the PC,
//  drives the instruction ROM, and returns the 16-bit word on instrucao.
//  Applies jump decisions requested by the controller on the next fetch.
//  Sits between Controle (request side) and the instruction ROM (memory side).
// PARAMETERS
//  ADDR_W    16  PC / ROM address width
//  RESET_PC  0   address fetched automatically after reset
//  ROM_LAT   1   ROM read latency in cycles, from the rom_ren cycle to valid rom_dado (>=1)
// PORTS
//  clock         in   1       single clock, rising edge
//  reset         in   1       asynchronous, active-low
//  controlePC    in   1       fetch-advance request from Controle
//  Rom_sink_ren  in   1       read enable from Controle
//  Rom_sink_cen  in   1       chip enable from Controle
//  salto_req     in   1       pulse: evaluate jump for the current instrucao
//  flag_cond     in   1       ALU condition flag used by JF/JT
//  salto_alvo    in   ADDR_W  register value used as the JR target
//  rom_addr      out  ADDR_W  ROM address (equals pc_atual)
//  rom_ren       out  1       ROM read strobe, one cycle per fetch
//  rom_dado      in   16      ROM read data
//  instrucao     out  16      last fetched instruction
//  inst_valida   out  1       instrucao is valid for the current pc_atual
//  ocupado       out  1       fetch in progress
//  pc_atual      out  ADDR_W  address of instrucao
//  pc_link       out  ADDR_W  pc_atual+1, the JAL link value
//  req_perdida   out  1       1-cycle pulse: request dropped while ocupado
// BEHAVIOUR
//  Fetch request = controlePC & Rom_sink_ren & Rom_sink_cen, sampled on a rising edge.
//  Reset (async, reset=0):
//   state=ENDERECA, pc_atual=rom_addr=RESET_PC, rom_ren=0, instrucao=16'h0000,
//   inst_valida=0, ocupado=1, salto_pend=0, req_perdida=0.
//   On release, an automatic fetch of RESET_PC runs with no request needed.
//  FSM:
//   OCIOSO:   ocupado=0. On a request: pc_atual <= salto_pend ? alvo_pend : pc_atual+1;
//             clear salto_pend and inst_valida; go to ENDERECA.
//   ENDERECA: rom_ren=1 for exactly this cycle; rom_addr=pc_atual; go to ESPERA.
//   ESPERA:   count ROM_LAT-1 cycles (zero when ROM_LAT=1); go to CAPTURA.
//   CAPTURA:  instrucao <= rom_dado; inst_valida <= 1; go to OCIOSO.
//  Latency: request at edge T -> rom_ren high in T+1 -> instrucao/inst_valida update
//   at edge T+ROM_LAT+2. inst_valida holds until the next accepted request.
//  Jump decision on salto_req (only when instrucao[15:14]==2'b00 and inst_valida=1;
//   otherwise ignored). Decoded from instrucao[13:11]:
//   00x JF: taken if flag_cond=0.
//   01x JT: taken if flag_cond=1.
//   10x J:  always taken.
//   For JF/JT/J: target = pc_atual + sext(instrucao[11:0]).
//   110 JAL: always taken; target = pc_atual + sext(instrucao[10:0]).
//   111 JR:  always taken; target = salto_alvo.
//   Taken: salto_pend<=1, alvo_pend<=target. Not taken: no change.
//  Arithmetic: all PC sums are modulo 2^ADDR_W; pc_atual = all-ones increments to 0.
//  salto_req and a request in the same edge: the jump is applied to that fetch.
//  A second salto_req before the fetch: last taken target wins.
//  Request while ocupado=1: ignored, req_perdida pulses, PC unchanged.
//  Async reset mid-fetch: aborts at once; rom_ren drops the same cycle; salto_pend is lost.
// TESTING
//  1 Reset release, ROM_LAT=1, ROM[0]=16'h8A53 -> rom_ren in cycle 1; instrucao=16'h8A53,
//    inst_valida=1 at edge 3; pc_atual=0.
//  2 Three back-to-back requests, each after inst_valida -> pc_atual 1,2,3; rom_ren pulses once
//    per fetch; inst_valida low between request and capture.
//  3 pc_atual=5, instrucao=16'h0FFE (JF, offset -2), flag_cond=0, salto_req, then request
//    -> fetch addr 3. Repeat with flag_cond=1 -> addr 6.
//  4 instrucao=16'h3800 (JR), salto_alvo=16'h0040, salto_req and request in the same edge
//    -> rom_addr=0x40; pc_link before the jump = old pc+1.
//  5 Request during ESPERA with ROM_LAT=3 -> req_perdida pulses for 1 cycle; PC advances
//    only once; capture occurs at edge T+5.
//  6 Assert reset in ENDERECA with a jump pending -> rom_ren=0 immediately; after release,
//    fetch of RESET_PC; salto_pend=0.

Source files
------------

// File: rtl/busca_instrucao.sv
// Instruction-fetch responder: owns the PC, strobes the instruction ROM
// and holds the fetched word plus any jump decided against it.
module busca_instrucao #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                ROM_LAT  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              controlePC,
    input  logic              Rom_sink_ren,
    input  logic              Rom_sink_cen,
    input  logic              salto_req,
    input  logic              flag_cond,
    input  logic [ADDR_W-1:0] salto_alvo,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_ren,
    input  logic [15:0]       rom_dado,
    output logic [15:0]       instrucao,
    output logic              inst_valida,
    output logic              ocupado,
    output logic [ADDR_W-1:0] pc_atual,
    output logic [ADDR_W-1:0] pc_link,
    output logic              req_perdida
);

    localparam int CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(ROM_LAT - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        ENDERECA,
        ESPERA,
        CAPTURA
    } estado_t;

    estado_t           estado;
    logic [CW-1:0]     cnt;
    logic              salto_pend;
    logic [ADDR_W-1:0] alvo_pend;

    logic              pedido;
    logic              salto_ok;
    logic              tomado;
    logic              salta;
    logic [ADDR_W-1:0] alvo;
    logic [ADDR_W-1:0] desl12;
    logic [ADDR_W-1:0] desl11;

    assign pedido = controlePC & Rom_sink_ren & Rom_sink_cen;

    assign desl12 = {{(ADDR_W-12){instrucao[11]}}, instrucao[11:0]};
    assign desl11 = {{(ADDR_W-11){instrucao[10]}}, instrucao[10:0]};

    // Jumps are only meaningful against a valid class-00 instruction.
    assign salto_ok = salto_req & inst_valida & (instrucao[15:14] == 2'b00);

    always_comb begin
        tomado = 1'b0;
        alvo   = pc_atual + desl12;
        case (instrucao[13:12])
            2'b00: tomado = ~flag_cond;
            2'b01: tomado = flag_cond;
            2'b10: tomado = 1'b1;
            default: begin
                tomado = 1'b1;
                alvo   = instrucao[11] ? salto_alvo
                                       : pc_atual + desl11;
            end
        endcase
    end

    assign salta = salto_ok & tomado;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado      <= ENDERECA;
            cnt         <= '0;
            pc_atual    <= RESET_PC;
            instrucao   <= 16'h0000;
            inst_valida <= 1'b0;
            salto_pend  <= 1'b0;
            alvo_pend   <= '0;
            req_perdida <= 1'b0;
        end else begin
            req_perdida <= pedido & (estado != OCIOSO);
            if (salta) begin
                salto_pend <= 1'b1;
                alvo_pend  <= alvo;
            end
            unique case (estado)
                OCIOSO: begin
                    if (pedido) begin
                        if (salta)
                            pc_atual <= alvo;
                        else if (salto_pend)
                            pc_atual <= alvo_pend;
                        else
                            pc_atual <= pc_atual + ADDR_W'(1);
                        salto_pend  <= 1'b0;
                        inst_valida <= 1'b0;
                        estado      <= ENDERECA;
                    end
                end
                ENDERECA: begin
                    cnt    <= '0;
                    estado <= ESPERA;
                end
                ESPERA: begin
                    if (cnt == ULTIMO)
                        estado <= CAPTURA;
                    else
                        cnt <= cnt + CW'(1);
                end
                CAPTURA: begin
                    instrucao   <= rom_dado;
                    inst_valida <= 1'b1;
                    estado      <= OCIOSO;
                end
            endcase
        end
    end

    // Gated by reset so the strobe dies the instant a fetch is aborted.
    assign rom_ren  = (estado == ENDERECA) & reset;
    assign rom_addr = pc_atual;
    assign ocupado  = (estado != OCIOSO);
    assign pc_link  = pc_atual + ADDR_W'(1);

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed bench for busca_instrucao: a ROM_LAT=1 instance for fetch
// and jump scenarios, a ROM_LAT=3 instance for latency and drop checks.
module tb_busca_instrucao;

    logic        clock;
    logic        reset;
    logic        controlePC;
    logic        ren;
    logic        cen;
    logic        salto_req;
    logic        flag_cond;
    logic [15:0] salto_alvo;
    logic [15:0] rom_addr;
    logic        rom_ren;
    logic [15:0] rom_dado;
    logic [15:0] instrucao;
    logic        inst_valida;
    logic        ocupado;
    logic [15:0] pc_atual;
    logic [15:0] pc_link;
    logic        req_perdida;

    logic        b_req;
    logic [15:0] b_rom_addr;
    logic        b_rom_ren;
    logic [15:0] b_rom_dado;
    logic [15:0] b_instrucao;
    logic        b_inst_valida;
    logic        b_ocupado;
    logic [15:0] b_pc;
    logic [15:0] b_pc_link;
    logic        b_req_perdida;

    logic [15:0] mem [0:65535];
    logic [15:0] addr_a;
    logic [15:0] addr_b;
    int          rens_a = 0;
    int          rens_b = 0;
    int          n_vec  = 0;
    int          n_err  = 0;

    busca_instrucao #(.ADDR_W(16), .RESET_PC(16'h0000), .ROM_LAT(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .controlePC   (controlePC),
        .Rom_sink_ren (ren),
        .Rom_sink_cen (cen),
        .salto_req    (salto_req),
        .flag_cond    (flag_cond),
        .salto_alvo   (salto_alvo),
        .rom_addr     (rom_addr),
        .rom_ren      (rom_ren),
        .rom_dado     (rom_dado),
        .instrucao    (instrucao),
        .inst_valida  (inst_valida),
        .ocupado      (ocupado),
        .pc_atual     (pc_atual),
        .pc_link      (pc_link),
        .req_perdida  (req_perdida)
    );

    busca_instrucao #(.ADDR_W(16), .RESET_PC(16'h0000), .ROM_LAT(3)) dut_b (
        .clock        (clock),
        .reset        (reset),
        .controlePC   (b_req),
        .Rom_sink_ren (1'b1),
        .Rom_sink_cen (1'b1),
        .salto_req    (1'b0),
        .flag_cond    (1'b0),
        .salto_alvo   (16'h0000),
        .rom_addr     (b_rom_addr),
        .rom_ren      (b_rom_ren),
        .rom_dado     (b_rom_dado),
        .instrucao    (b_instrucao),
        .inst_valida  (b_inst_valida),
        .ocupado      (b_ocupado),
        .pc_atual     (b_pc),
        .pc_link      (b_pc_link),
        .req_perdida  (b_req_perdida)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (rom_ren) begin
            addr_a <= rom_addr;
            rens_a <= rens_a + 1;
        end
        if (b_rom_ren) begin
            addr_b <= b_rom_addr;
            rens_b <= rens_b + 1;
        end
    end
    assign rom_dado   = mem[addr_a];
    assign b_rom_dado = mem[addr_b];

    task automatic pedir();
        controlePC = 1'b1;
        @(posedge clock); #1;
        controlePC = 1'b0;
    endtask

    task automatic saltar(input logic f, input logic [15:0] a);
        flag_cond  = f;
        salto_alvo = a;
        salto_req  = 1'b1;
        @(posedge clock); #1;
        salto_req  = 1'b0;
    endtask

    task automatic aguardar(output int n);
        n = 0;
        while (!inst_valida && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        n_vec++;
        if ({rom_ren, inst_valida, ocupado, req_perdida} !== 4'b0010) begin
            n_err++;
            $display("FAIL reset_flags got=%b exp=0010",
                     {rom_ren, inst_valida, ocupado, req_perdida});
        end
        n_vec++;
        if ({instrucao, pc_atual, rom_addr} !== 48'h0) begin
            n_err++;
            $display("FAIL reset_regs got=%h exp=0", {instrucao, pc_atual, rom_addr});
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (rom_ren !== 1'b1) begin
            n_err++;
            $display("FAIL reset_autofetch_ren got=%b exp=1", rom_ren);
        end
        aguardar(n);
        n_vec++;
        if (n !== 3) begin
            n_err++;
            $display("FAIL reset_latency got=%0d exp=3", n);
        end
        n_vec++;
        if ({instrucao, pc_atual, ocupado} !== {16'h8A53, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_fetch got=%h/%h/%b exp=8a53/0000/0",
                     instrucao, pc_atual, ocupado);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_i [3];
        int n;
        int r0;
        exp_i = '{16'h3800, 16'h9222, 16'hC333};
        saltar(1'b0, 16'h0040);
        for (int i = 1; i <= 3; i++) begin
            r0 = rens_a;
            pedir();
            n_vec++;
            if ({inst_valida, rom_ren, rom_addr} !== {1'b0, 1'b1, 16'(i)}) begin
                n_err++;
                $display("FAIL b2b_issue%0d got=%b/%b/%h exp=0/1/%h",
                         i, inst_valida, rom_ren, rom_addr, 16'(i));
            end
            aguardar(n);
            n_vec++;
            if (n !== 3 || pc_atual !== 16'(i) || instrucao !== exp_i[i-1]) begin
                n_err++;
                $display("FAIL b2b_capture%0d got=%0d/%h/%h exp=3/%h/%h",
                         i, n, pc_atual, instrucao, 16'(i), exp_i[i-1]);
            end
            n_vec++;
            if (rens_a - r0 !== 1) begin
                n_err++;
                $display("FAIL b2b_ren_pulses%0d got=%0d exp=1", i, rens_a - r0);
            end
        end
    endtask

    task automatic test_jf();
        int n;
        pedir(); aguardar(n);
        pedir(); aguardar(n);
        n_vec++;
        if ({pc_atual, instrucao} !== {16'h0005, 16'h0FFE}) begin
            n_err++;
            $display("FAIL jf_setup got=%h/%h exp=0005/0ffe", pc_atual, instrucao);
        end
        saltar(1'b0, 16'h0000);
        pedir();
        n_vec++;
        if (rom_addr !== 16'h0003) begin
            n_err++;
            $display("FAIL jf_taken got=%h exp=0003", rom_addr);
        end
        aguardar(n);
        n_vec++;
        if (instrucao !== 16'hC333) begin
            n_err++;
            $display("FAIL jf_taken_data got=%h exp=c333", instrucao);
        end
        pedir(); aguardar(n);
        pedir(); aguardar(n);
        saltar(1'b1, 16'h0000);
        pedir();
        n_vec++;
        if (rom_addr !== 16'h0006) begin
            n_err++;
            $display("FAIL jf_not_taken got=%h exp=0006", rom_addr);
        end
        aguardar(n);
    endtask

    task automatic test_jr();
        int n;
        n_vec++;
        if (pc_link !== 16'h0007 || instrucao !== 16'h3800) begin
            n_err++;
            $display("FAIL jr_link got=%h/%h exp=0007/3800", pc_link, instrucao);
        end
        salto_alvo = 16'h0040;
        salto_req  = 1'b1;
        controlePC = 1'b1;
        @(posedge clock); #1;
        salto_req  = 1'b0;
        controlePC = 1'b0;
        n_vec++;
        if ({rom_ren, rom_addr} !== {1'b1, 16'h0040}) begin
            n_err++;
            $display("FAIL jr_same_edge got=%b/%h exp=1/0040", rom_ren, rom_addr);
        end
        aguardar(n);
        n_vec++;
        if (pc_link !== 16'h0041) begin
            n_err++;
            $display("FAIL jr_link_after got=%h exp=0041", pc_link);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        saltar(1'b0, 16'h1111);
        saltar(1'b0, 16'h1234);
        cen = 1'b0;
        pedir();
        cen = 1'b1;
        n_vec++;
        if ({ocupado, pc_atual} !== {1'b0, 16'h0040}) begin
            n_err++;
            $display("FAIL cen_gating got=%b/%h exp=0/0040", ocupado, pc_atual);
        end
        pedir();
        n_vec++;
        if ({rom_ren, rom_addr} !== {1'b1, 16'h1234}) begin
            n_err++;
            $display("FAIL last_jump_wins got=%b/%h exp=1/1234", rom_ren, rom_addr);
        end
        #1 reset = 1'b0;
        #1;
        n_vec++;
        if ({rom_ren, ocupado, inst_valida, pc_atual} !== {3'b010, 16'h0000}) begin
            n_err++;
            $display("FAIL abort got=%b%b%b/%h exp=010/0000",
                     rom_ren, ocupado, inst_valida, pc_atual);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        aguardar(n);
        n_vec++;
        if (n !== 3 || instrucao !== 16'h8A53) begin
            n_err++;
            $display("FAIL abort_refetch got=%0d/%h exp=3/8a53", n, instrucao);
        end
        pedir();
        n_vec++;
        if (rom_addr !== 16'h0001) begin
            n_err++;
            $display("FAIL abort_pend_lost got=%h exp=0001", rom_addr);
        end
        aguardar(n);
    endtask

    task automatic test_wrap();
        int n;
        saltar(1'b0, 16'hFFFF);
        pedir();
        aguardar(n);
        n_vec++;
        if ({pc_atual, instrucao, pc_link} !== {16'hFFFF, 16'h5A5A, 16'h0000}) begin
            n_err++;
            $display("FAIL wrap_top got=%h/%h/%h exp=ffff/5a5a/0000",
                     pc_atual, instrucao, pc_link);
        end
        pedir();
        n_vec++;
        if (rom_addr !== 16'h0000) begin
            n_err++;
            $display("FAIL wrap_zero got=%h exp=0000", rom_addr);
        end
        aguardar(n);
    endtask

    task automatic test_latency_drop();
        int n;
        int r0;
        n = 0;
        while (!b_inst_valida && n < 30) begin
            @(posedge clock); #1;
            n++;
        end
        n_vec++;
        if (b_inst_valida !== 1'b1) begin
            n_err++;
            $display("FAIL lat3_ready got=%b exp=1", b_inst_valida);
        end
        r0 = rens_b;
        b_req = 1'b1;
        @(posedge clock); #1;
        b_req = 1'b0;
        @(posedge clock); #1;
        b_req = 1'b1;
        @(posedge clock); #1;
        b_req = 1'b0;
        n_vec++;
        if ({b_req_perdida, b_pc} !== {1'b1, 16'h0001}) begin
            n_err++;
            $display("FAIL lat3_drop got=%b/%h exp=1/0001", b_req_perdida, b_pc);
        end
        @(posedge clock); #1;
        n_vec++;
        if (b_req_perdida !== 1'b0) begin
            n_err++;
            $display("FAIL lat3_drop_pulse got=%b exp=0", b_req_perdida);
        end
        @(posedge clock); #1;
        n_vec++;
        if (b_inst_valida !== 1'b0) begin
            n_err++;
            $display("FAIL lat3_early got=%b exp=0", b_inst_valida);
        end
        @(posedge clock); #1;
        n_vec++;
        if ({b_inst_valida, b_instrucao, b_pc} !== {1'b1, 16'h3800, 16'h0001}) begin
            n_err++;
            $display("FAIL lat3_capture got=%b/%h/%h exp=1/3800/0001",
                     b_inst_valida, b_instrucao, b_pc);
        end
        n_vec++;
        if (rens_b - r0 !== 1 || b_pc_link !== 16'h0002) begin
            n_err++;
            $display("FAIL lat3_single_fetch got=%0d/%h exp=1/0002",
                     rens_b - r0, b_pc_link);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h8A53;
        mem[16'h0001] = 16'h3800;
        mem[16'h0002] = 16'h9222;
        mem[16'h0003] = 16'hC333;
        mem[16'h0004] = 16'h4444;
        mem[16'h0005] = 16'h0FFE;
        mem[16'h0006] = 16'h3800;
        mem[16'h0040] = 16'h3800;
        mem[16'h1234] = 16'hA1B2;
        mem[16'hFFFF] = 16'h5A5A;
        addr_a     = 16'h0000;
        addr_b     = 16'h0000;
        reset      = 1'b0;
        controlePC = 1'b0;
        ren        = 1'b1;
        cen        = 1'b1;
        salto_req  = 1'b0;
        flag_cond  = 1'b0;
        salto_alvo = 16'h0000;
        b_req      = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        test_reset();
        test_back_to_back();
        test_jf();
        test_jr();
        test_reset_abort();
        test_wrap();
        test_latency_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
